control_pipeline: RTL and testbench
===================================

Name: control_pipeline

Overview:
- Consumes the decoded control bundle produced at ID by the control unit.
- Carries the bundle through ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards, taken control transfers and data-memory waits, and drives the PC/IF-ID enable and flush signals.
- Sits beside the datapath pipeline registers and owns only control, not data.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- id_ALUSrc  in  2  ALU operand select from decoder
- id_ALUOp  in  aluop_t  ALU operation from decoder
- id_RegSel  in  2  writeback source select
- id_RegWr  in  1  register write enable
- id_RegDst  in  regbits_t  destination register
- id_PCSrc  in  2  next-PC select; 0 = sequential
- id_dREN, id_dWEN  in  1 each  data memory read/write request
- id_ExtOp  in  1  immediate extension (0 zero, 1 sign)
- id_rs, id_rt  in  regbits_t  source registers of the ID instruction
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data memory access complete this cycle
- ex_taken  in  1  EX-stage control transfer resolved taken (branch true or jump)
- ex_*  out  one per id_* control field  EX-stage control bundle
- mem_dREN, mem_dWEN, mem_RegWr, mem_RegSel, mem_RegDst  out  MEM-stage controls
- wb_RegWr, wb_RegSel, wb_RegDst  out  WB-stage controls
- pc_en  out  1  PC may advance
- ifid_en  out  1  IF/ID register may load
- ifid_flush  out  1  IF/ID register loads a bubble
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Bubble encoding: every field zero (RegWr=0, dREN=0, dWEN=0, PCSrc=0, RegDst=0, ALUOp=0).
- Reset (nRST=0, asynchronous):
  - EX, MEM and WB registers hold the bubble.
  - state=RUN, stall_cnt=0.
  - pc_en=0, ifid_en=0, ifid_flush=0 while reset is held.
- FSM states: RUN, MEM_WAIT, LU_STALL.
- MEM_WAIT (highest priority):
  - Entered, or held, when the MEM stage has dREN|dWEN set and dhit=0.
  - All stage registers freeze; pc_en=0, ifid_en=0.
  - Returns to RUN in the cycle after dhit=1; on the dhit cycle itself all stages advance.
- Load-use:
  - Detected when ex_dREN=1, ex_RegWr=1, ex_RegDst≠0 and ex_RegDst equals id_rs or id_rt.
  - Action: the bubble is written into EX; IF/ID and PC hold; MEM and WB advance.
  - Occupies exactly 1 cycle in LU_STALL, then RUN.
  - Register 0 never causes a stall.
- Taken transfer (ex_PCSrc≠0 and ex_taken=1, not in MEM_WAIT):
  - ifid_flush=1 and pc_en=1.
  - The bubble is written into EX in place of the ID bundle.
  - Takes precedence over load-use in the same cycle.
- Fetch miss (ihit=0 in RUN): the bubble is written into EX, pc_en=0, ifid_en=0, and downstream stages advance.
- Normal advance: ID→EX→MEM→WB on each rising edge with a 1-cycle latency per stage; pc_en=ifid_en=1.
- Stage coupling: mem_* fields are the previous cycle's ex_* fields; wb_* fields are the previous mem_* fields.
- stall_cnt:
  - Increments on every post-reset cycle with pc_en=0.
  - Saturates at 2^CNT_W−1 and never wraps.
- Reset mid-operation: any state returns to RUN and all stages return to the bubble immediately.

Decomposition:
- cpu_types_pkg gains:
  - ctrl_bundle_t, a packed struct of all id_* control fields.
  - the CTRL_BUBBLE constant.
  - cp_state_t enum {RUN, MEM_WAIT, LU_STALL}.
- One sub-module, hazard_detect: combinational load-use and taken-transfer detection feeding the FSM.

Test Plan:
- Reset: hold nRST=0 for 3 cycles with non-zero id_* inputs → all ex_/mem_/wb_ outputs 0, stall_cnt=0; after release with ihit=1, a bundle with RegDst=7 appears on wb_RegDst 3 cycles after entering ID.
- Load-use: ID holds a load with RegDst=5, then an instruction with rs=5 → one cycle with pc_en=0 and the bubble in EX, then normal advance; stall_cnt=1.
- $0 load-use: load with RegDst=0, then an instruction with rs=0 → no stall.
- Taken branch: ex_PCSrc=1 and ex_taken=1 → ifid_flush=1; next cycle ex_RegWr=0 and ex_dWEN=0.
- Memory wait: MEM holds a store and dhit is held low for 3 cycles → all stages frozen for 3 cycles, pc_en=0, stall_cnt+=3; the store leaves MEM on the dhit cycle.
- Simultaneous/reset: load-use condition and MEM_WAIT asserted together → MEM_WAIT wins, then a 1-cycle LU_STALL; pulse nRST low during MEM_WAIT → state RUN with all stages at the bubble immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: register/ALU encodings, the decoded control
// bundle carried down the pipeline, and the control-pipeline FSM states.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef struct packed {
        logic [1:0] ALUSrc;
        aluop_t     ALUOp;
        logic [1:0] RegSel;
        logic       RegWr;
        regbits_t   RegDst;
        logic [1:0] PCSrc;
        logic       dREN;
        logic       dWEN;
        logic       ExtOp;
    } ctrl_bundle_t;

    // MEM and WB only need the fields still consumed downstream
    typedef struct packed {
        logic       dREN;
        logic       dWEN;
        logic       RegWr;
        logic [1:0] RegSel;
        regbits_t   RegDst;
    } mem_ctrl_t;

    typedef struct packed {
        logic       RegWr;
        logic [1:0] RegSel;
        regbits_t   RegDst;
    } wb_ctrl_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;
    localparam mem_ctrl_t    MEM_BUBBLE  = '0;
    localparam wb_ctrl_t     WB_BUBBLE   = '0;

    typedef enum logic [1:0] {RUN, MEM_WAIT, LU_STALL} cp_state_t;

endpackage

// File: rtl/control_pipeline_if.sv
// Control-pipeline bundle: decoded ID controls and handshakes in, staged
// controls and PC/IF-ID steering out.
interface control_pipeline_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [1:0]       id_ALUSrc;
    aluop_t           id_ALUOp;
    logic [1:0]       id_RegSel;
    logic             id_RegWr;
    regbits_t         id_RegDst;
    logic [1:0]       id_PCSrc;
    logic             id_dREN;
    logic             id_dWEN;
    logic             id_ExtOp;
    regbits_t         id_rs;
    regbits_t         id_rt;
    logic             ihit;
    logic             dhit;
    logic             ex_taken;

    logic [1:0]       ex_ALUSrc;
    aluop_t           ex_ALUOp;
    logic [1:0]       ex_RegSel;
    logic             ex_RegWr;
    regbits_t         ex_RegDst;
    logic [1:0]       ex_PCSrc;
    logic             ex_dREN;
    logic             ex_dWEN;
    logic             ex_ExtOp;

    logic             mem_dREN;
    logic             mem_dWEN;
    logic             mem_RegWr;
    logic [1:0]       mem_RegSel;
    regbits_t         mem_RegDst;

    logic             wb_RegWr;
    logic [1:0]       wb_RegSel;
    regbits_t         wb_RegDst;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_ALUSrc, id_ALUOp, id_RegSel, id_RegWr, id_RegDst, id_PCSrc,
               id_dREN, id_dWEN, id_ExtOp, id_rs, id_rt, ihit, dhit, ex_taken,
        input  ex_ALUSrc, ex_ALUOp, ex_RegSel, ex_RegWr, ex_RegDst, ex_PCSrc,
               ex_dREN, ex_dWEN, ex_ExtOp,
               mem_dREN, mem_dWEN, mem_RegWr, mem_RegSel, mem_RegDst,
               wb_RegWr, wb_RegSel, wb_RegDst,
               pc_en, ifid_en, ifid_flush, stall_cnt
    );

    modport slave (
        input  id_ALUSrc, id_ALUOp, id_RegSel, id_RegWr, id_RegDst, id_PCSrc,
               id_dREN, id_dWEN, id_ExtOp, id_rs, id_rt, ihit, dhit, ex_taken,
        output ex_ALUSrc, ex_ALUOp, ex_RegSel, ex_RegWr, ex_RegDst, ex_PCSrc,
               ex_dREN, ex_dWEN, ex_ExtOp,
               mem_dREN, mem_dWEN, mem_RegWr, mem_RegSel, mem_RegDst,
               wb_RegWr, wb_RegSel, wb_RegDst,
               pc_en, ifid_en, ifid_flush, stall_cnt
    );
endinterface

// File: rtl/control_pipeline_hazard_detect.sv
// Combinational hazard detection: load-use against the ID sources and
// taken control transfers resolved in EX.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic       ex_dREN,
    input  logic       ex_RegWr,
    input  regbits_t   ex_RegDst,
    input  logic [1:0] ex_PCSrc,
    input  logic       ex_taken,
    input  regbits_t   id_rs,
    input  regbits_t   id_rt,
    output logic       load_use,
    output logic       taken
);
    // $0 is hardwired, so a load targeting it can never create a dependency
    assign load_use = ex_dREN & ex_RegWr & (ex_RegDst != '0) &
                      ((ex_RegDst == id_rs) | (ex_RegDst == id_rt));

    assign taken = (ex_PCSrc != 2'b00) & ex_taken;
endmodule

// File: rtl/control_pipeline.sv
// Control side of the 5-stage pipeline: ID/EX, EX/MEM, MEM/WB control
// registers, stall/flush steering and a saturating stall-cycle counter.
module control_pipeline
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             CLK,
    input  logic             nRST,
    control_pipeline_if.slave cp
);
    ctrl_bundle_t      id_b;
    ctrl_bundle_t      ex_p0;
    mem_ctrl_t         mem_p1;
    wb_ctrl_t          wb_p2;
    cp_state_t         state, state_n;
    logic [CNT_W-1:0]  stall_cnt;
    logic              load_use, taken, mem_busy;
    logic              adv, load_id, pc_en, ifid_en, ifid_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        id_b        = CTRL_BUBBLE;
        id_b.ALUSrc = cp.id_ALUSrc;
        id_b.ALUOp  = cp.id_ALUOp;
        id_b.RegSel = cp.id_RegSel;
        id_b.RegWr  = cp.id_RegWr;
        id_b.RegDst = cp.id_RegDst;
        id_b.PCSrc  = cp.id_PCSrc;
        id_b.dREN   = cp.id_dREN;
        id_b.dWEN   = cp.id_dWEN;
        id_b.ExtOp  = cp.id_ExtOp;
    end

    assign mem_busy = (mem_p1.dREN | mem_p1.dWEN) & ~cp.dhit;

    hazard_detect u_hazard (
        .ex_dREN   (ex_p0.dREN),
        .ex_RegWr  (ex_p0.RegWr),
        .ex_RegDst (ex_p0.RegDst),
        .ex_PCSrc  (ex_p0.PCSrc),
        .ex_taken  (cp.ex_taken),
        .id_rs     (cp.id_rs),
        .id_rt     (cp.id_rt),
        .load_use  (load_use),
        .taken     (taken)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= state_n;
    end

    // Priority: memory wait > taken transfer > load-use > fetch miss > advance
    always_comb begin
        state_n    = state;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        adv        = 1'b0;
        load_id    = 1'b0;
        if (nRST) begin
            if (mem_busy) begin
                state_n = MEM_WAIT;
            end else begin
                adv     = 1'b1;
                state_n = RUN;
                if (taken) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end else if (load_use && state != LU_STALL) begin
                    state_n = LU_STALL;
                end else if (cp.ihit) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    load_id = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_p0     <= CTRL_BUBBLE;
            mem_p1    <= MEM_BUBBLE;
            wb_p2     <= WB_BUBBLE;
            stall_cnt <= '0;
        end else begin
            if (adv) begin
                // ID -> EX
                ex_p0         <= load_id ? id_b : CTRL_BUBBLE;
                // EX -> MEM
                mem_p1.dREN   <= ex_p0.dREN;
                mem_p1.dWEN   <= ex_p0.dWEN;
                mem_p1.RegWr  <= ex_p0.RegWr;
                mem_p1.RegSel <= ex_p0.RegSel;
                mem_p1.RegDst <= ex_p0.RegDst;
                // MEM -> WB
                wb_p2.RegWr   <= mem_p1.RegWr;
                wb_p2.RegSel  <= mem_p1.RegSel;
                wb_p2.RegDst  <= mem_p1.RegDst;
            end
            if (!pc_en) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign cp.ex_ALUSrc  = ex_p0.ALUSrc;
    assign cp.ex_ALUOp   = ex_p0.ALUOp;
    assign cp.ex_RegSel  = ex_p0.RegSel;
    assign cp.ex_RegWr   = ex_p0.RegWr;
    assign cp.ex_RegDst  = ex_p0.RegDst;
    assign cp.ex_PCSrc   = ex_p0.PCSrc;
    assign cp.ex_dREN    = ex_p0.dREN;
    assign cp.ex_dWEN    = ex_p0.dWEN;
    assign cp.ex_ExtOp   = ex_p0.ExtOp;

    assign cp.mem_dREN   = mem_p1.dREN;
    assign cp.mem_dWEN   = mem_p1.dWEN;
    assign cp.mem_RegWr  = mem_p1.RegWr;
    assign cp.mem_RegSel = mem_p1.RegSel;
    assign cp.mem_RegDst = mem_p1.RegDst;

    assign cp.wb_RegWr   = wb_p2.RegWr;
    assign cp.wb_RegSel  = wb_p2.RegSel;
    assign cp.wb_RegDst  = wb_p2.RegDst;

    assign cp.pc_en      = pc_en;
    assign cp.ifid_en    = ifid_en;
    assign cp.ifid_flush = ifid_flush;
    assign cp.stall_cnt  = stall_cnt;
endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: directed hazard scenarios then random traffic,
// all checked against a cycle-level model of the stage rules.
module tb_control_pipeline;
    import cpu_types_pkg::*;

    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    control_pipeline_if #(.CNT_W(CNT_W)) cp();
    control_pipeline #(.CNT_W(CNT_W)) dut (.CLK(CLK), .nRST(nRST), .cp(cp.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model: contents of each stage, whether the last cycle was a load-use stall
    ctrl_bundle_t m_ex, m_mem, m_wb;
    bit m_lu;
    int m_cnt;
    bit hold_id, flush_id;

    function automatic ctrl_bundle_t mk(input int dst, input bit wr, input bit rd,
                                        input bit wn, input int pcs);
        ctrl_bundle_t b;
        b        = '0;
        b.ALUOp  = ALU_ADD;
        b.ALUSrc = 2'd1;
        b.RegSel = 2'(rd ? 1 : 0);
        b.RegDst = regbits_t'(dst);
        b.RegWr  = wr;
        b.dREN   = rd;
        b.dWEN   = wn;
        b.PCSrc  = 2'(pcs);
        b.ExtOp  = 1'b1;
        return b;
    endfunction

    function automatic ctrl_bundle_t rnd_bundle();
        ctrl_bundle_t b;
        b.ALUSrc = 2'($urandom_range(0, 3));
        b.ALUOp  = aluop_t'(4'($urandom_range(0, 9)));
        b.RegSel = 2'($urandom_range(0, 3));
        b.RegWr  = 1'($urandom_range(0, 1));
        b.RegDst = regbits_t'($urandom_range(0, 7));
        b.PCSrc  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        b.dREN   = ($urandom_range(0, 2) == 0);
        b.dWEN   = !b.dREN && ($urandom_range(0, 5) == 0);
        b.ExtOp  = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic set_id(input ctrl_bundle_t b, input int rs, input int rt);
        cp.id_ALUSrc = b.ALUSrc;
        cp.id_ALUOp  = b.ALUOp;
        cp.id_RegSel = b.RegSel;
        cp.id_RegWr  = b.RegWr;
        cp.id_RegDst = b.RegDst;
        cp.id_PCSrc  = b.PCSrc;
        cp.id_dREN   = b.dREN;
        cp.id_dWEN   = b.dWEN;
        cp.id_ExtOp  = b.ExtOp;
        cp.id_rs     = regbits_t'(rs);
        cp.id_rt     = regbits_t'(rt);
    endtask

    function automatic ctrl_bundle_t id_now();
        ctrl_bundle_t b;
        b = '{cp.id_ALUSrc, cp.id_ALUOp, cp.id_RegSel, cp.id_RegWr, cp.id_RegDst,
              cp.id_PCSrc, cp.id_dREN, cp.id_dWEN, cp.id_ExtOp};
        return b;
    endfunction

    function automatic ctrl_bundle_t ex_now();
        ctrl_bundle_t b;
        b = '{cp.ex_ALUSrc, cp.ex_ALUOp, cp.ex_RegSel, cp.ex_RegWr, cp.ex_RegDst,
              cp.ex_PCSrc, cp.ex_dREN, cp.ex_dWEN, cp.ex_ExtOp};
        return b;
    endfunction

    // Compare the DUT to the model for this cycle, then apply this cycle's edge.
    task automatic model_step();
        ctrl_bundle_t id;
        bit busy, tk, lu, go;
        id = id_now();
        if (!nRST) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_lu = 0; m_cnt = 0;
        end
        busy = nRST && (m_mem.dREN || m_mem.dWEN) && !cp.dhit;
        tk   = (m_ex.PCSrc != 2'd0) && cp.ex_taken;
        lu   = m_ex.dREN && m_ex.RegWr && (m_ex.RegDst != 0) && !m_lu &&
               (m_ex.RegDst == cp.id_rs || m_ex.RegDst == cp.id_rt);
        go   = nRST && !busy && (tk || (!lu && cp.ihit));

        check_val("ex_bundle", 32'(ex_now()), 32'(m_ex));
        check_val("mem_ctrl", 32'({cp.mem_dREN, cp.mem_dWEN, cp.mem_RegWr, cp.mem_RegSel, cp.mem_RegDst}),
                  32'({m_mem.dREN, m_mem.dWEN, m_mem.RegWr, m_mem.RegSel, m_mem.RegDst}));
        check_val("wb_ctrl", 32'({cp.wb_RegWr, cp.wb_RegSel, cp.wb_RegDst}),
                  32'({m_wb.RegWr, m_wb.RegSel, m_wb.RegDst}));
        check_val("pc_en", 32'(cp.pc_en), 32'(go));
        check_val("ifid_en", 32'(cp.ifid_en), 32'(go));
        check_val("ifid_flush", 32'(cp.ifid_flush), 32'(nRST && !busy && tk));
        check_val("stall_cnt", 32'(cp.stall_cnt), 32'(m_cnt));

        if (nRST) begin
            if (!go && m_cnt < CNT_MAX) m_cnt++;
            if (busy) begin
                m_lu = 0;
            end else begin
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = (go && !tk) ? id : '0;
                m_lu  = lu && !tk;
            end
        end
        hold_id  = !go;
        flush_id = nRST && !busy && tk;
    endtask

    task automatic eval();
        #1;
        model_step();
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    int base;

    initial begin
        nRST = 1'b1;
        set_id(mk(7, 1, 1, 0, 1), 3, 4);
        cp.ihit = 1'b1; cp.dhit = 1'b0; cp.ex_taken = 1'b1;
        #2 nRST = 1'b0;

        // Reset held for three cycles with live inputs
        for (int i = 0; i < 3; i++) begin
            eval();
            check_val("rst_wb_dst", 32'(cp.wb_RegDst), 32'd0);
            check_val("rst_cnt", 32'(cp.stall_cnt), 32'd0);
            check_val("rst_pc_en", 32'(cp.pc_en), 32'd0);
            tick();
        end

        // Release: RegDst=7 reaches WB three cycles after entering ID
        nRST = 1'b1; cp.dhit = 1'b1; cp.ex_taken = 1'b0;
        set_id(mk(7, 1, 0, 0, 0), 0, 0);
        eval(); tick();
        set_id('0, 0, 0);
        eval(); tick();
        eval(); tick();
        eval();
        check_val("lat_wb_dst", 32'(cp.wb_RegDst), 32'd7);
        tick();

        // Load-use on $5
        set_id(mk(5, 1, 1, 0, 0), 0, 0);
        eval(); tick();
        set_id(mk(9, 1, 0, 0, 0), 5, 2);
        eval();
        check_val("lu_pc_en", 32'(cp.pc_en), 32'd0);
        check_val("lu_ifid_en", 32'(cp.ifid_en), 32'd0);
        tick();
        eval();
        check_val("lu_ex_bubble", 32'({cp.ex_RegWr, cp.ex_dREN, cp.ex_RegDst}), 32'd0);
        check_val("lu_cnt", 32'(cp.stall_cnt), 32'd1);
        check_val("lu_resume", 32'(cp.pc_en), 32'd1);
        tick();
        eval();
        check_val("lu_ex_dst", 32'(cp.ex_RegDst), 32'd9);
        tick();

        // Load into $0 never stalls
        set_id(mk(0, 1, 1, 0, 0), 0, 0);
        eval(); tick();
        set_id(mk(3, 1, 0, 0, 0), 0, 0);
        eval();
        check_val("lu_zero_pc_en", 32'(cp.pc_en), 32'd1);
        tick();

        // Taken branch flushes IF/ID and bubbles EX
        set_id(mk(0, 0, 0, 0, 1), 0, 0);
        eval(); tick();
        set_id(mk(4, 1, 0, 1, 0), 0, 0);
        cp.ex_taken = 1'b1;
        eval();
        check_val("br_flush", 32'(cp.ifid_flush), 32'd1);
        check_val("br_pc_en", 32'(cp.pc_en), 32'd1);
        tick();
        cp.ex_taken = 1'b0;
        set_id('0, 0, 0);
        eval();
        check_val("br_ex_bubble", 32'({cp.ex_RegWr, cp.ex_dWEN}), 32'd0);
        tick();

        // Store waits three cycles in MEM
        set_id(mk(0, 0, 0, 1, 0), 0, 0);
        eval(); tick();
        set_id('0, 0, 0);
        eval(); tick();
        set_id(mk(6, 1, 0, 0, 0), 0, 0);
        cp.dhit = 1'b0;
        base = m_cnt;
        for (int i = 0; i < 3; i++) begin
            eval();
            check_val("mw_pc_en", 32'(cp.pc_en), 32'd0);
            check_val("mw_mem_dwen", 32'(cp.mem_dWEN), 32'd1);
            tick();
        end
        cp.dhit = 1'b1;
        eval();
        check_val("mw_release", 32'(cp.pc_en), 32'd1);
        check_val("mw_cnt", 32'(cp.stall_cnt), 32'(base + 3));
        tick();
        eval();
        check_val("mw_store_left", 32'(cp.mem_dWEN), 32'd0);
        tick();

        // Memory wait coinciding with a load-use
        set_id(mk(0, 0, 0, 1, 0), 0, 0);
        eval(); tick();
        set_id(mk(8, 1, 1, 0, 0), 0, 0);
        eval(); tick();
        set_id(mk(2, 1, 0, 0, 0), 8, 0);
        cp.dhit = 1'b0;
        eval();
        check_val("sim_freeze_ex", 32'(cp.ex_dREN), 32'd1);
        check_val("sim_pc_en", 32'(cp.pc_en), 32'd0);
        tick();
        cp.dhit = 1'b1;
        eval();
        check_val("sim_lu_pc_en", 32'(cp.pc_en), 32'd0);
        tick();
        eval();
        check_val("sim_lu_bubble", 32'({cp.ex_RegWr, cp.ex_dREN}), 32'd0);
        check_val("sim_load_mem", 32'(cp.mem_dREN), 32'd1);
        check_val("sim_resume", 32'(cp.pc_en), 32'd1);
        tick();

        // Reset pulse during a memory wait
        set_id(mk(0, 0, 0, 1, 0), 0, 0);
        eval(); tick();
        set_id('0, 0, 0);
        eval(); tick();
        cp.dhit = 1'b0;
        eval(); tick();
        nRST = 1'b0;
        eval();
        check_val("rstmw_mem", 32'(cp.mem_dWEN), 32'd0);
        check_val("rstmw_cnt", 32'(cp.stall_cnt), 32'd0);
        tick();
        nRST = 1'b1;
        eval();
        check_val("rstmw_run", 32'(cp.pc_en), 32'd1);
        tick();

        // Random traffic; IF/ID holds when disabled and empties after a flush
        for (int c = 0; c < 1500; c++) begin
            nRST = ($urandom_range(0, 199) != 0);
            if (!hold_id) begin
                if (flush_id) set_id('0, 0, 0);
                else          set_id(rnd_bundle(), $urandom_range(0, 7), $urandom_range(0, 7));
            end
            cp.ihit     = ($urandom_range(0, 6) != 0);
            cp.dhit     = ($urandom_range(0, 2) != 0);
            cp.ex_taken = 1'($urandom_range(0, 1));
            eval();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
